seg_share_arb: RTL and testbench

SEG_SHARE_ARB -- requirements
Module: seg_share_arb

---
 rtl/seg_share_arb.sv | 177 +++++++++++++++++
 tb/tb_seg_share_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_share_arb.sv
// seg_share_arb
//   Lets two clients share one 7-segment digit. Each client has a request
//   and a BCD digit. Once a client is granted the display, it keeps it for
//   at least DWELL prescaler ticks. A tie between the two clients goes to
//   the client that was not served last.
//
// Parameters
//   TICK_MAX  prescaler terminal count; one tick every TICK_MAX+1 clocks
//   DWELL     minimum number of ticks a grant is held (1..15)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous reset, active low
//   req_a      client A requests the display
//   digit_a    client A BCD digit
//   req_b      client B requests the display
//   digit_b    client B BCD digit
//   gnt_a      registered; display owned by A
//   gnt_b      registered; display owned by B
//   seg        active-high segments, bit6 = a ... bit0 = g
//   bad_digit  latched digit is above 9
module seg_share_arb #(
  parameter int TICK_MAX = 50000000,
  parameter int DWELL    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] digit_a,
  input  logic       req_b,
  input  logic [3:0] digit_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [6:0] seg,
  output logic       bad_digit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [26:0] TICK_TC  = 27'(TICK_MAX);
  localparam logic [3:0]  DWELL_TC = 4'(DWELL);

  state_t      state_q, state_d;
  logic [26:0] presc_q, presc_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [3:0]  digit_q, digit_d;
  logic        last_b_q, last_b_d;
  logic        gnt_a_q, gnt_b_q;

  logic tick;
  logic done;
  logic entry_a;
  logic entry_b;

  // Bit 7 flags a non-BCD digit; bits 6:0 are the segment pattern.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = 8'b0_1111110;
      4'd1:    r = 8'b0_0110000;
      4'd2:    r = 8'b0_1101101;
      4'd3:    r = 8'b0_1111001;
      4'd4:    r = 8'b0_0110011;
      4'd5:    r = 8'b0_1011011;
      4'd6:    r = 8'b0_1011111;
      4'd7:    r = 8'b0_1110000;
      4'd8:    r = 8'b0_1111111;
      4'd9:    r = 8'b0_1111011;
      default: r = 8'b1_0000001;
    endcase
    return r;
  endfunction

  // Free-running prescaler
  assign tick    = (presc_q == TICK_TC);
  assign presc_d = tick ? 27'd0 : presc_q + 27'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign done = (dwell_q == DWELL_TC);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_b_q ? OWN_A : OWN_B;
        else if (req_a)     state_d = OWN_A;
        else if (req_b)     state_d = OWN_B;
      end
      OWN_A: begin
        // Until the dwell expires the grant is held whatever the requests do.
        if (done) begin
          if (req_b)      state_d = OWN_B;
          else if (!req_a) state_d = IDLE;
        end
      end
      OWN_B: begin
        if (done) begin
          if (req_a)      state_d = OWN_A;
          else if (!req_b) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: seg and bad_digit are decoded from the current state and
  // the latched digit, so they follow reset immediately.
  always_comb begin
    logic [7:0] dec;
    dec       = seg_decode(digit_q);
    seg       = 7'b0000000;
    bad_digit = 1'b0;
    if (state_q != IDLE) begin
      seg       = dec[6:0];
      bad_digit = dec[7];
    end
  end

  // Dwell counter, digit latch and fairness flag
  assign entry_a = (state_d == OWN_A) && (state_q != OWN_A);
  assign entry_b = (state_d == OWN_B) && (state_q != OWN_B);

  always_comb begin
    dwell_d  = dwell_q;
    digit_d  = digit_q;
    last_b_d = last_b_q;

    // On entry, a tick in the same cycle is ignored, so the dwell always
    // starts from a full count.
    if (entry_a || entry_b)             dwell_d = 4'd0;
    else if (state_d == IDLE)           dwell_d = 4'd0;
    else if (tick && !done)             dwell_d = dwell_q + 4'd1;

    if (entry_a)                        digit_d = digit_a;
    else if (entry_b)                   digit_d = digit_b;
    else if (state_q == OWN_A && req_a) digit_d = digit_a;
    else if (state_q == OWN_B && req_b) digit_d = digit_b;

    if (entry_a)      last_b_d = 1'b0;
    else if (entry_b) last_b_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q  <= '0;
      digit_q  <= '0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      dwell_q  <= dwell_d;
      digit_q  <= digit_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;

endmodule

// File: tb/tb_seg_share_arb.sv
// tb_seg_share_arb
//   Directed bench for seg_share_arb with TICK_MAX=3 and DWELL=2. Every test
//   starts from a reset, so the prescaler phase is known. After release,
//   ticks are taken on the 4th, 8th, 12th, ... rising edges.
module tb_seg_share_arb;

  logic       clk;
  logic       reset;
  logic       req_a;
  logic [3:0] digit_a;
  logic       req_b;
  logic [3:0] digit_b;
  logic       gnt_a;
  logic       gnt_b;
  logic [6:0] seg;
  logic       bad_digit;

  int n_tests = 0;
  int n_fail  = 0;

  seg_share_arb #(
    .TICK_MAX (3),
    .DWELL    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .digit_a   (digit_a),
    .req_b     (req_b),
    .digit_b   (digit_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .seg       (seg),
    .bad_digit (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge, check that it acts at once, then
  // let one edge pass with reset still low.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    chk_eq({tag, "_gnt_a"}, 32'(gnt_a), 32'd0);
    chk_eq({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
    chk_eq({tag, "_seg"},   32'(seg),   32'd0);
    step();
  endtask

  initial begin
    int errs;
    int prev_t;
    int period;
    int drops;

    reset   = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    digit_a = 4'd0;
    digit_b = 4'd0;

    // Reset state
    repeat (2) step();
    chk_eq("rst_gnt_a", 32'(gnt_a),     32'd0);
    chk_eq("rst_gnt_b", 32'(gnt_b),     32'd0);
    chk_eq("rst_seg",   32'(seg),       32'd0);
    chk_eq("rst_bad",   32'(bad_digit), 32'd0);

    // Single request from A, digit re-latching, bad digit, then hold and release
    reset = 1'b1; req_a = 1'b1; digit_a = 4'd5;
    step();                                              // E1
    chk_eq("a_gnt_a", 32'(gnt_a), 32'd1);
    chk_eq("a_gnt_b", 32'(gnt_b), 32'd0);
    chk_eq("a_seg5",  32'(seg),   32'b1011011);
    chk_eq("a_bad5",  32'(bad_digit), 32'd0);
    digit_a = 4'd3;
    step();                                              // E2
    chk_eq("a_seg3",  32'(seg), 32'b1111001);
    digit_a = 4'd12;
    step();                                              // E3
    chk_eq("a_seg12", 32'(seg), 32'b0000001);
    chk_eq("a_bad12", 32'(bad_digit), 32'd1);
    req_a = 1'b0; digit_a = 4'd2;
    step();                                              // E4
    chk_eq("a_hold_seg", 32'(seg),   32'b0000001);
    chk_eq("a_hold_gnt", 32'(gnt_a), 32'd1);
    repeat (4) step();                                   // E8: dwell just reached
    chk_eq("a_dwell_gnt", 32'(gnt_a), 32'd1);
    step();                                              // E9: back to IDLE
    chk_eq("a_idle_gnt", 32'(gnt_a),     32'd0);
    chk_eq("a_idle_seg", 32'(seg),       32'd0);
    chk_eq("a_idle_bad", 32'(bad_digit), 32'd0);

    // Tie after reset: A first, then B with no IDLE gap, then A again
    do_reset("r2");
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; digit_a = 4'd1; digit_b = 4'd2;
    step();                                              // E1
    chk_eq("tie_gnt_a", 32'(gnt_a), 32'd1);
    chk_eq("tie_gnt_b", 32'(gnt_b), 32'd0);
    chk_eq("tie_seg1",  32'(seg),   32'b0110000);
    errs = 0;
    repeat (7) begin                                     // E2..E8
      step();
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) errs++;
    end
    chk_eq("tie_a_held", 32'(errs), 32'd0);
    step();                                              // E9
    chk_eq("tie_sw_gnt_a", 32'(gnt_a), 32'd0);
    chk_eq("tie_sw_gnt_b", 32'(gnt_b), 32'd1);
    chk_eq("tie_sw_seg2",  32'(seg),   32'b1101101);
    errs = 0;
    repeat (7) begin                                     // E10..E16
      step();
      if (gnt_a !== 1'b0 || gnt_b !== 1'b1) errs++;
    end
    chk_eq("tie_b_held", 32'(errs), 32'd0);
    step();                                              // E17
    chk_eq("tie_back_gnt_a", 32'(gnt_a), 32'd1);
    chk_eq("tie_back_gnt_b", 32'(gnt_b), 32'd0);

    // One-cycle pulse on B, entry at E4 where a tick is also taken
    do_reset("r3");
    reset = 1'b1; digit_b = 4'd7;
    repeat (3) step();                                   // E1..E3
    req_b = 1'b1;
    step();                                              // E4
    chk_eq("pulse_gnt_b", 32'(gnt_b), 32'd1);
    chk_eq("pulse_seg7",  32'(seg),   32'b1110000);
    req_b = 1'b0; digit_b = 4'd3;
    errs = 0;
    drops = 0;
    repeat (8) begin                                     // E5..E12
      step();
      if (gnt_b !== 1'b1)       drops++;
      if (seg !== 7'b1110000)   errs++;
    end
    chk_eq("pulse_held_gnt", 32'(drops), 32'd0);
    chk_eq("pulse_held_seg", 32'(errs),  32'd0);
    step();                                              // E13
    chk_eq("pulse_end_gnt", 32'(gnt_b), 32'd0);
    chk_eq("pulse_end_seg", 32'(seg),   32'd0);

    // Reset in the middle of an OWN_B grant
    do_reset("r4");
    reset = 1'b1; req_b = 1'b1; digit_b = 4'd4;
    step();
    chk_eq("mid_gnt_b", 32'(gnt_b), 32'd1);
    chk_eq("mid_seg4",  32'(seg),   32'b0110011);
    reset = 1'b0;
    #1;
    chk_eq("mid_rst_gnt_b", 32'(gnt_b), 32'd0);
    chk_eq("mid_rst_seg",   32'(seg),   32'd0);
    step();
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; digit_a = 4'd6;
    step();
    chk_eq("mid_tie_gnt_a", 32'(gnt_a), 32'd1);
    chk_eq("mid_tie_gnt_b", 32'(gnt_b), 32'd0);
    chk_eq("mid_tie_seg6",  32'(seg),   32'b1011111);

    // Continuous A with B idle; measure the tick period
    do_reset("r5");
    reset = 1'b1; req_a = 1'b1; digit_a = 4'd8;
    drops  = 0;
    prev_t = -1;
    period = 0;
    errs   = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (gnt_a !== 1'b1) drops++;
      if (dut.tick === 1'b1) begin
        if (prev_t >= 0) begin
          if (period == 0)             period = t - prev_t;
          else if (t - prev_t != period) errs++;
        end
        prev_t = t;
      end
    end
    chk_eq("cont_gnt_a",     32'(drops),  32'd0);
    chk_eq("cont_seg8",      32'(seg),    32'b1111111);
    chk_eq("tick_period",    32'(period), 32'd4);
    chk_eq("tick_period_eq", 32'(errs),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
